// File: rtl/conv3x3_mac.sv
// conv3x3_mac: applies a 3x3 signed kernel plus bias to heap window taps through a
// 3-stage pipeline, tracks the window anchor for valid-padding output, and loads the kernel.
module conv3x3_mac #(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned WW    = 8,
    parameter int unsigned ACC_W = 24,
    parameter int unsigned IMG_W = 32,
    parameter int unsigned IMG_H = 32,
    parameter int unsigned RELU  = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           clear,
    input  logic                           win_stb,
    input  logic signed [WIDTH-1:0]        tap0,
    input  logic signed [WIDTH-1:0]        tap1,
    input  logic signed [WIDTH-1:0]        tap2,
    input  logic signed [WIDTH-1:0]        tap3,
    input  logic signed [WIDTH-1:0]        tap4,
    input  logic signed [WIDTH-1:0]        tap5,
    input  logic signed [WIDTH-1:0]        tap6,
    input  logic signed [WIDTH-1:0]        tap7,
    input  logic signed [WIDTH-1:0]        tap8,
    input  logic                           wt_start,
    input  logic signed [ACC_W-1:0]        bias_data,
    input  logic                           wt_valid,
    input  logic signed [WW-1:0]           wt_data,
    output logic                           ready,
    output logic                           out_valid,
    output logic signed [ACC_W-1:0]        out_data,
    output logic [$clog2(IMG_H)-1:0]       out_row,
    output logic [$clog2(IMG_W)-1:0]       out_col
);

    localparam int unsigned RW   = $clog2(IMG_H);
    localparam int unsigned CW   = $clog2(IMG_W);
    localparam int unsigned PW   = WIDTH + WW;
    localparam int unsigned SW   = PW + 2;
    localparam int unsigned FILL = 2 * IMG_W + IMG_W - 1;
    localparam int unsigned FW   = $clog2(FILL + 1);
    localparam int unsigned KW   = 4;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN
    } state_t;

    state_t                   state;
    logic [KW-1:0]            beat;
    logic signed [WW-1:0]     w [9];
    logic signed [ACC_W-1:0]  bias;

    logic [FW-1:0]            fill_cnt;
    logic [RW-1:0]            row;
    logic [CW-1:0]            col;
    logic                     filled_c;
    logic                     accept_c;
    logic                     flush_c;

    logic signed [WIDTH-1:0]  taps [9];
    logic signed [PW-1:0]     prod [9];
    logic signed [SW-1:0]     rsum [3];
    logic                     v1;
    logic                     v2;
    logic [RW-1:0]            row1;
    logic [RW-1:0]            row2;
    logic [CW-1:0]            col1;
    logic [CW-1:0]            col2;
    logic signed [ACC_W-1:0]  sum_c;
    logic signed [ACC_W-1:0]  res_c;

    always_comb begin
        taps[0] = tap0;
        taps[1] = tap1;
        taps[2] = tap2;
        taps[3] = tap3;
        taps[4] = tap4;
        taps[5] = tap5;
        taps[6] = tap6;
        taps[7] = tap7;
        taps[8] = tap8;
    end

    // Kernel load FSM; a new wt_start always restarts the load, even mid-load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ready <= 1'b0;
            beat  <= '0;
            bias  <= '0;
            for (int i = 0; i < 9; i++) begin
                w[i] <= '0;
            end
        end else if (wt_start) begin
            state <= LOAD;
            ready <= 1'b0;
            beat  <= '0;
            bias  <= bias_data;
        end else if (state == LOAD && wt_valid) begin
            w[beat] <= wt_data;
            if (beat == KW'(8)) begin
                state <= RUN;
                ready <= 1'b1;
                beat  <= '0;
            end else begin
                beat <= beat + KW'(1);
            end
        end
    end

    assign filled_c = (fill_cnt == FW'(FILL));
    assign flush_c  = clear | wt_start;
    assign accept_c = win_stb && !flush_c && filled_c && (state == RUN)
                      && (row <= RW'(IMG_H - 3)) && (col <= CW'(IMG_W - 3));

    // Heap fill and raster anchor tracking; runs regardless of load state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_cnt <= '0;
            row      <= '0;
            col      <= '0;
        end else if (clear) begin
            fill_cnt <= '0;
            row      <= '0;
            col      <= '0;
        end else if (win_stb) begin
            if (!filled_c) begin
                fill_cnt <= fill_cnt + FW'(1);
            end else if (col == CW'(IMG_W - 1)) begin
                col <= '0;
                row <= (row == RW'(IMG_H - 1)) ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // Stage 1: per-tap products.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1   <= 1'b0;
            row1 <= '0;
            col1 <= '0;
            for (int i = 0; i < 9; i++) begin
                prod[i] <= '0;
            end
        end else begin
            v1 <= accept_c;
            if (accept_c) begin
                row1 <= row;
                col1 <= col;
                for (int i = 0; i < 9; i++) begin
                    prod[i] <= PW'(taps[i]) * PW'(w[i]);
                end
            end
        end
    end

    // Stage 2: row sums.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2   <= 1'b0;
            row2 <= '0;
            col2 <= '0;
            for (int k = 0; k < 3; k++) begin
                rsum[k] <= '0;
            end
        end else begin
            v2 <= v1 && !flush_c;
            if (v1) begin
                row2 <= row1;
                col2 <= col1;
                for (int k = 0; k < 3; k++) begin
                    rsum[k] <= SW'(prod[3*k]) + SW'(prod[3*k+1]) + SW'(prod[3*k+2]);
                end
            end
        end
    end

    always_comb begin
        sum_c = ACC_W'(rsum[0]) + ACC_W'(rsum[1]) + ACC_W'(rsum[2]) + bias;
        res_c = sum_c;
        if (RELU != 0 && sum_c[ACC_W-1]) begin
            res_c = '0;
        end
    end

    // Stage 3: bias, optional ReLU, registered result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_row   <= '0;
            out_col   <= '0;
        end else begin
            out_valid <= v2 && !flush_c;
            if (v2) begin
                out_data <= res_c;
                out_row  <= row2;
                out_col  <= col2;
            end
        end
    end

endmodule

// File: doc/conv3x3_mac.md
Name: conv3x3_mac

Overview:
- Downstream consumer of the 3-row x 32-column window shift heap in the conv datapath.
- Takes the nine window taps on each heap shift and applies a 3x3 signed weight kernel plus bias, with optional ReLU, through a 3-stage pipeline.
- Tracks the window anchor position and emits only windows that lie fully inside the image (valid-padding conv).
- Owns the weight/bias load state machine for its kernel.

Parameters:
- WIDTH, 9, signed pixel/tap width; must equal the heap WIDTH.
- WW, 8, signed weight width.
- ACC_W, 24, signed accumulator, bias and result width; must be at least WIDTH+WW+4.
- IMG_W, 32, image width; must equal the heap row length.
- IMG_H, 32, image height.
- RELU, 1, 1 = clamp negative results to 0; 0 = pass the signed result.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- clear  in  1  synchronous restart of fill/anchor counters and pipeline flush.
- win_stb  in  1  high in any cycle where the taps reflect a new heap shift.
- tap0..tap8  in  WIDTH each  window taps; tap0..2 = top row oldest-first, tap3..5 = middle row, tap6..8 = bottom row.
- wt_start  in  1  starts a kernel load; bias_data is sampled in the same cycle.
- bias_data  in  ACC_W  signed bias.
- wt_valid  in  1  weight beat strobe.
- wt_data  in  WW  signed weight; beats arrive in tap order w0..w8.
- ready  out  1  kernel loaded; computation enabled.
- out_valid  out  1  single-cycle result strobe.
- out_data  out  ACC_W  signed result.
- out_row  out  clog2(IMG_H)  anchor row of the result.
- out_col  out  clog2(IMG_W)  anchor column of the result.

Behaviour:
- Reset (async, active-low): state IDLE, ready=0, out_valid=0, out_data/out_row/out_col=0, all counters, weights, bias and pipeline valids cleared.
- Load FSM states: IDLE, LOAD, RUN.
  - wt_start in any state -> LOAD; bias latched; beat count=0; ready=0; in-flight pipeline valids dropped.
  - In LOAD, each wt_valid writes w[count] and increments count. On beat 9, go to RUN and set ready=1 from the next cycle.
  - wt_valid outside LOAD is ignored. wt_start wins over a simultaneous wt_valid.
- Position tracking runs in every state, so the heap fill state is never lost.
  - Fill counter: the first 2*IMG_W+IMG_W-1 strobes (95 at default) after reset/clear produce no result.
  - From the next strobe on, anchor (row,col) starts at (0,0) and advances raster-order per strobe. col wraps IMG_W-1 -> 0 with row+1; row wraps IMG_H-1 -> 0. Frames run back-to-back with no refill.
- A strobe is accepted only when all of these hold: fill complete, row<=IMG_H-3, col<=IMG_W-3, and state RUN.
  - Default: 30x30 = 900 accepted windows per 1024 strobes.
  - Rejected strobes still advance the anchor.
- Pipeline for an accepted strobe in cycle t:
  - Edge end of t: nine products tap_i*w_i registered (signed, WIDTH+WW bits).
  - Edge end of t+1: three row sums registered (signed, +2 bits).
  - Edge end of t+2: row sums + bias, sign-extended to ACC_W, then ReLU if RELU=1, registered.
  - out_valid=1 in cycle t+3 only; out_row/out_col carry the anchor of strobe t.
- Throughput: one result per cycle; consecutive strobes are fully pipelined and there is no back-pressure.
- No saturation: ACC_W is sized to hold the worst case, 9*(-2^(WIDTH-1))*(-2^(WW-1)) + bias.
- clear: fill and anchor counters reset; pipeline valids flushed; weights and state kept.
- clear and win_stb in the same cycle: clear wins and the strobe is not counted.
- Reset mid-pipeline: all pending results are lost; no out_valid after rst_n deasserts until the full fill plus acceptance conditions are met again.

Test Plan:
- Weight load: wt_start with bias=5, then nine beats w=1 -> ready rises the cycle after beat 9. Every tap=1, first accepted strobe -> out_data=14 exactly 3 cycles later.
- Fill and anchor: ready kernel, continuous strobes from reset -> strobes 1-95 give no out_valid. Strobe 96 -> out_valid with (row,col)=(0,0). One full frame of 1024 strobes -> exactly 900 out_valids. No valid for col 30/31 or rows 30/31.
- Signed/ReLU: weights -1, taps 255, bias 0 -> RELU=1 gives 0; RELU=0 gives -2295. Taps -256, weights -128, bias 0 -> +294912.
- Back-to-back: 30 consecutive accepted strobes -> 30 consecutive out_valid cycles with ascending out_col 0..29 and matching per-window sums.
- Reload mid-stream: wt_start while results are in flight -> in-flight results suppressed and ready=0. Strobes during LOAD give no output but the anchor still advances. After reload, the first result uses the new kernel at the correct anchor.
- Async reset mid-pipeline, and clear coincident with win_stb -> outputs go to 0 immediately on reset. The counter restarts and the next 95 strobes are silent.
